// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - multi-cycle 24-bit unsigned multiply/divide sequencer on the shared ALU
//
// Borrows the CPU's shared ALU for one add or subtract per cycle. Multiply is
// shift-add and divide is restoring. While busy it holds Stall and AluOwn high.
//
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-low reset
//   Start, IsDiv        request (sampled only in IDLE), 0 = multiply / 1 = divide
//   OpA, OpB            multiplicand / dividend, multiplier / divisor
//   AluResult, AluCout  shared ALU result bus and carry-out
//   AluA, AluB          ALU operands driven while the sequencer owns the ALU
//   AluBinvert, AluCin  ALU B-invert and carry-in (both 1 for subtract)
//   AluOp               ALU operation select
//   AluOwn, Stall       ALU input mux steering, datapath freeze
//   Done                one-cycle completion pulse
//   Hi, Lo              product[47:24] / remainder, product[23:0] / quotient
//   DivZero             last divide had a zero divisor
module alu_muldiv_seq #(
  parameter int         WIDTH  = 24,
  parameter logic [2:0] OP_ADD = 3'd2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             IsDiv,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluCout,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic             AluBinvert,
  output logic             AluCin,
  output logic [2:0]       AluOp,
  output logic             AluOwn,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivZero
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc: P_hi for multiply, R for divide
  // sh:  P_lo for multiply, Q for divide
  // m:   multiplicand M or divisor D
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             divzero_q, divzero_d;

  // Restoring-divide step terms. The spill bit is the bit shifted out of R;
  // when it is set the partial remainder already exceeds D, so the subtract
  // always succeeds and AluResult's low WIDTH bits are the correct remainder.
  logic [WIDTH-1:0] div_s;
  logic             div_spill;
  logic             div_qb;

  assign div_s     = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
  assign div_spill = acc_q[WIDTH-1];
  assign div_qb    = div_spill | AluCout;

  // State and datapath registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divzero_q <= divzero_d;
    end
  end

  // Next state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divzero_d = divzero_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (IsDiv && (OpB == '0)) begin
            // Divide by zero completes immediately without borrowing the ALU
            state_d   = S_DONE;
            hi_d      = OpA;
            lo_d      = '1;
            divzero_d = 1'b1;
          end else begin
            state_d = IsDiv ? S_DIV : S_MUL;
            cnt_d   = CNT_LOAD;
            acc_d   = '0;
            sh_d    = IsDiv ? OpA : OpB;
            m_d     = IsDiv ? OpB : OpA;
          end
        end
      end

      S_MUL: begin
        // {AluCout, AluResult, P_lo} shifted right by one
        acc_d = {AluCout, AluResult[WIDTH-1:1]};
        sh_d  = {AluResult[0], sh_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d   = S_DONE;
          hi_d      = acc_d;
          lo_d      = sh_d;
          divzero_d = 1'b0;
        end
      end

      S_DIV: begin
        acc_d = div_qb ? AluResult : div_s;
        sh_d  = {sh_q[WIDTH-2:0], div_qb};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d   = S_DONE;
          hi_d      = acc_d;
          lo_d      = sh_d;
          divzero_d = 1'b0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state and registered datapath only
  always_comb begin
    AluA       = '0;
    AluB       = '0;
    AluBinvert = 1'b0;
    AluCin     = 1'b0;
    AluOp      = 3'd0;
    AluOwn     = 1'b0;
    Stall      = 1'b0;
    Done       = 1'b0;

    unique case (state_q)
      S_MUL: begin
        AluA   = acc_q;
        AluB   = sh_q[0] ? m_q : '0;
        AluOp  = OP_ADD;
        AluOwn = 1'b1;
        Stall  = 1'b1;
      end
      S_DIV: begin
        AluA       = div_s;
        AluB       = m_q;
        AluOp      = OP_ADD;
        AluBinvert = 1'b1;
        AluCin     = 1'b1;
        AluOwn     = 1'b1;
        Stall      = 1'b1;
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign DivZero = divzero_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq against an arithmetic reference
module tb_alu_muldiv_seq;

  localparam int W = 24;

  logic         Clock, Reset, Start, IsDiv;
  logic [W-1:0] OpA, OpB, AluResult;
  logic         AluCout;
  logic [W-1:0] AluA, AluB, Hi, Lo;
  logic         AluBinvert, AluCin, AluOwn, Stall, Done, DivZero;
  logic [2:0]   AluOp;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_muldiv_seq #(.WIDTH(W), .OP_ADD(3'd2)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .IsDiv(IsDiv),
    .OpA(OpA), .OpB(OpB), .AluResult(AluResult), .AluCout(AluCout),
    .AluA(AluA), .AluB(AluB), .AluBinvert(AluBinvert), .AluCin(AluCin),
    .AluOp(AluOp), .AluOwn(AluOwn), .Stall(Stall), .Done(Done),
    .Hi(Hi), .Lo(Lo), .DivZero(DivZero)
  );

  // Shared ALU: adder with optional B inversion and carry-in
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    if (AluOp == 3'd2)
      alu_sum = {1'b0, AluA} + {1'b0, (AluBinvert ? ~AluB : AluB)} + {{W{1'b0}}, AluCin};
  end
  assign AluResult = alu_sum[W-1:0];
  assign AluCout   = alu_sum[W];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic
  task automatic model(input logic isdiv, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    logic [2*W-1:0] prod;
    if (!isdiv) begin
      prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      hi = prod[2*W-1:W];
      lo = prod[W-1:0];
      dz = 1'b0;
    end else if (b == '0) begin
      hi = a;
      lo = {W{1'b1}};
      dz = 1'b1;
    end else begin
      hi = a % b;
      lo = a / b;
      dz = 1'b0;
    end
  endtask

  // Called just after an edge; counts cycles until Done, optionally poking Start mid-run
  task automatic wait_done(input int poke_at, output int cycles, output int stalls, output int own_bad);
    cycles  = 0;
    stalls  = 0;
    own_bad = 0;
    while (Done !== 1'b1 && cycles < 200) begin
      if (Stall === 1'b1) stalls++;
      if (AluOwn !== Stall || (Stall === 1'b1 && AluOp !== 3'd2)) own_bad++;
      if (cycles == poke_at) begin
        Start = 1'b1;
        IsDiv = 1'b1;
        OpA   = W'($urandom);
        OpB   = '0;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clock);
      #1;
      cycles++;
    end
    Start = 1'b0;
    check_eq("done_timeout", 64'(cycles >= 200), 64'd0);
  endtask

  task automatic do_op(input logic isdiv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int poke_at, input bit start_next);
    logic [W-1:0] ehi, elo;
    logic         edz;
    int           cyc, stl, bad, exp_lat;
    model(isdiv, a, b, ehi, elo, edz);
    exp_lat = (isdiv && b == '0) ? 0 : W;
    @(negedge Clock);
    Start = 1'b1;
    IsDiv = isdiv;
    OpA   = a;
    OpB   = b;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    wait_done(poke_at, cyc, stl, bad);
    check_eq("latency", 64'(cyc), 64'(exp_lat));
    check_eq("stall_cycles", 64'(stl), 64'(exp_lat));
    check_eq("own_op_bad", 64'(bad), 64'd0);
    check_eq("hi", 64'(Hi), 64'(ehi));
    check_eq("lo", 64'(Lo), 64'(elo));
    check_eq("divzero", 64'(DivZero), 64'(edz));
    check_eq("done_stall", {62'd0, Stall, AluOwn}, 64'd0);
    if (start_next) begin
      Start = 1'b1;
      IsDiv = 1'b0;
      OpA   = 24'd6;
      OpB   = 24'd7;
    end
    @(posedge Clock);
    #1;
    check_eq("done_one_cycle", 64'(Done), 64'd0);
    check_eq("idle_stall", {62'd0, Stall, AluOwn}, 64'd0);
    check_eq("idle_alu", {AluA, AluB, AluBinvert, AluCin, AluOp}, 64'd0);
    check_eq("hold_hi", 64'(Hi), 64'(ehi));
    check_eq("hold_lo", 64'(Lo), 64'(elo));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {Hi, Lo, 16'd0}, 64'd0);
    check_eq(tag, {AluA, AluB, 16'd0}, 64'd0);
    check_eq(tag, {56'd0, DivZero, Done, Stall, AluOwn, AluBinvert, AluCin, AluOp[1:0]}, 64'd0);
    check_eq(tag, 64'(AluOp), 64'd0);
  endtask

  initial begin
    int cyc, stl, bad;
    logic [W-1:0] ra, rb;
    logic         rd;

    Reset = 1'b0;
    Start = 1'b0;
    IsDiv = 1'b0;
    OpA   = '0;
    OpB   = '0;
    repeat (3) @(posedge Clock);
    #1;
    check_all_zero("reset_state");
    @(negedge Clock);
    Reset = 1'b1;

    // Directed cases
    do_op(1'b0, 24'd3, 24'd5, -1, 1'b0);
    do_op(1'b0, 24'hFFFFFF, 24'hFFFFFF, -1, 1'b0);
    do_op(1'b1, 24'd100, 24'd7, -1, 1'b0);
    do_op(1'b1, 24'hFFFFFF, 24'h800001, -1, 1'b0);
    do_op(1'b1, 24'h123456, 24'd0, -1, 1'b0);
    do_op(1'b1, 24'd5, 24'd9, -1, 1'b0);

    // Start during MUL must be ignored
    do_op(1'b0, 24'd3, 24'd5, 5, 1'b0);

    // Start in DONE ignored, then accepted in the following IDLE cycle
    do_op(1'b1, 24'd1000, 24'd33, -1, 1'b1);
    @(posedge Clock);
    #1;
    Start = 1'b0;
    check_eq("next_accept_stall", 64'(Stall), 64'd1);
    wait_done(-1, cyc, stl, bad);
    check_eq("next_latency", 64'(cyc), 64'(W));
    check_eq("next_lo", 64'(Lo), 64'd42);
    check_eq("next_hi", 64'(Hi), 64'd0);
    @(posedge Clock);
    #1;

    // Reset in the middle of a divide
    @(negedge Clock);
    Start = 1'b1;
    IsDiv = 1'b1;
    OpA   = 24'd1000000;
    OpB   = 24'd3;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (9) @(posedge Clock);
    #1;
    check_eq("middiv_stall", 64'(Stall), 64'd1);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    check_all_zero("middiv_reset");
    @(negedge Clock);
    Reset = 1'b1;
    do_op(1'b0, 24'd6, 24'd7, -1, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom);
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = W'($urandom_range(0, 10));
        1:       rb = W'($urandom) >> $urandom_range(0, 20);
        default: rb = W'($urandom);
      endcase
      do_op(rd, ra, rb, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
